pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/core_ctrl_pkg.sv | 42 ++++
 rtl/hazard_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the core pipeline: hazard-controller FSM states,
// event priority indices and the priority resolver used in the RUN state.
// Purely declarative; no clocked logic lives here.
package core_ctrl_pkg;

    // Hazard controller states.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LOAD_USE = 3'd1,
        ST_MDU_WAIT = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } ctrl_state_e;

    // Bit positions in the event request vector; lower index wins.
    localparam int unsigned PRIO_TRAP     = 0;
    localparam int unsigned PRIO_MEM      = 1;
    localparam int unsigned PRIO_MDU      = 2;
    localparam int unsigned PRIO_REDIR    = 3;
    localparam int unsigned PRIO_LOAD_USE = 4;
    localparam int unsigned NUM_EV        = 5;

    // Winning event after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_TRAP     = 3'd1,
        EV_MEM      = 3'd2,
        EV_MDU      = 3'd3,
        EV_REDIR    = 3'd4,
        EV_LOAD_USE = 3'd5
    } ctrl_ev_e;

    function automatic ctrl_ev_e pick_event(input logic [NUM_EV-1:0] req);
        if (req[PRIO_TRAP])     return EV_TRAP;
        if (req[PRIO_MEM])      return EV_MEM;
        if (req[PRIO_MDU])      return EV_MDU;
        if (req[PRIO_REDIR])    return EV_REDIR;
        if (req[PRIO_LOAD_USE]) return EV_LOAD_USE;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EXE-stage load and the ID-stage sources.
// Latency: combinational. Backpressure: none, pure compare.
// Ports: rs1_i/rs2_i ID sources, rd_i EXE destination, mem_read_i EXE is a load,
//        load_use_o high when the ID instruction needs the load result.
module hazard_detect (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    input  logic       mem_read_i,
    output logic       load_use_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use_o = mem_read_i && (rd_i != 5'd0) &&
                        ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: generates per-stage stall and flush strobes for
// load-use, multi-cycle MDU, data-bus waits, redirects and traps.
// Latency: outputs are combinational from state and inputs (zero-cycle in RUN).
// Backpressure: stalls hold pipeline registers until dmem_ack / mdu_done arrive;
//               a data-bus wait is abandoned after MEM_TIMEOUT cycles.
// Ports: hazard inputs from ID/EXE/MEM, stall_* per pipeline register,
//        flush_* bubble inserts, mem_timeout_o pulse, stall_count statistic.
module pipeline_hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,    // >= 1
    parameter int unsigned MEM_TIMEOUT  = 255,  // >= 1
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_exe,
    input  logic             mem_read_exe,
    input  logic             redirect_exe,
    input  logic             trap_req,
    input  logic             mdu_start_exe,
    input  logic             mdu_done,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    // Flush entered from a wait state has not flushed yet: full length.
    localparam logic [FCNT_W-1:0] FLUSH_FULL = FCNT_W'(FLUSH_CYCLES);
    // Flush entered from RUN already flushed in the trigger cycle.
    localparam logic [FCNT_W-1:0] FLUSH_REST = FCNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;   // flush cycles left, including current
    logic              trap_pend_q, trap_pend_d;
    logic              mdu_done_q, mdu_done_d;     // mdu_done seen while dmem still busy
    logic [CNT_W-1:0]  stall_count_q;

    logic              load_use;
    logic              dmem_wait;
    logic              mdu_fin;
    logic              wait_done;
    logic              trap_svc;
    logic [NUM_EV-1:0] ev_req;
    ctrl_ev_e          ev;

    logic s_if, s_id, s_exe, s_mem, f_if_id, f_id_exe, tmo;

    hazard_detect u_hazard_detect (
        .rs1_i      (rs1_id),
        .rs2_i      (rs2_id),
        .rd_i       (rd_exe),
        .mem_read_i (mem_read_exe),
        .load_use_o (load_use)
    );

    assign dmem_wait = dmem_req_mem & ~dmem_ack;
    assign trap_svc  = trap_pend_q | trap_req;

    // In LOAD_USE the EXE stage holds the bubble just inserted, so the hazard
    // compare is masked; all other events are evaluated exactly as in RUN.
    always_comb begin
        ev_req                = '0;
        ev_req[PRIO_TRAP]     = trap_req;
        ev_req[PRIO_MEM]      = dmem_wait;
        ev_req[PRIO_MDU]      = mdu_start_exe & ~mdu_done;
        ev_req[PRIO_REDIR]    = redirect_exe;
        ev_req[PRIO_LOAD_USE] = load_use & (state_q == ST_RUN);
        ev                    = pick_event(ev_req);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        trap_pend_d = trap_pend_q;
        mdu_done_d  = mdu_done_q;
        mdu_fin     = 1'b0;
        wait_done   = 1'b0;
        s_if        = 1'b0;
        s_id        = 1'b0;
        s_exe       = 1'b0;
        s_mem       = 1'b0;
        f_if_id     = 1'b0;
        f_id_exe    = 1'b0;
        tmo         = 1'b0;

        case (state_q)
            ST_RUN, ST_LOAD_USE: begin
                state_d = ST_RUN;
                case (ev)
                    EV_TRAP, EV_REDIR: begin
                        f_if_id  = 1'b1;
                        f_id_exe = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_REST;
                        end
                    end
                    EV_MEM: begin
                        s_if       = 1'b1;
                        s_id       = 1'b1;
                        s_exe      = 1'b1;
                        s_mem      = 1'b1;
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                    EV_MDU: begin
                        s_if       = 1'b1;
                        s_id       = 1'b1;
                        s_exe      = 1'b1;
                        state_d    = ST_MDU_WAIT;
                        mdu_done_d = 1'b0;
                    end
                    EV_LOAD_USE: begin
                        s_if     = 1'b1;
                        s_id     = 1'b1;
                        f_id_exe = 1'b1;
                        state_d  = ST_LOAD_USE;
                    end
                    default: ;
                endcase
            end

            ST_MEM_WAIT: begin
                // Ack wins over a simultaneous timeout: the access did complete.
                wait_done = dmem_ack | (wait_cnt_q == WAIT_LIMIT);
                if (wait_done) begin
                    tmo        = ~dmem_ack;
                    wait_cnt_d = '0;
                    if (trap_svc) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_FULL;
                        trap_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    s_if        = 1'b1;
                    s_id        = 1'b1;
                    s_exe       = 1'b1;
                    s_mem       = 1'b1;
                    wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
                    trap_pend_d = trap_svc;
                end
            end

            ST_MDU_WAIT: begin
                // mdu_done may be a single-cycle pulse; remember it while a
                // data-bus wait is still holding the MEM stage.
                mdu_fin = mdu_done | mdu_done_q;
                if (mdu_fin && !dmem_wait) begin
                    mdu_done_d = 1'b0;
                    if (trap_svc) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_FULL;
                        trap_pend_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    s_if        = 1'b1;
                    s_id        = 1'b1;
                    s_exe       = 1'b1;
                    s_mem       = dmem_wait;
                    mdu_done_d  = mdu_fin;
                    trap_pend_d = trap_svc;
                end
            end

            ST_FLUSH: begin
                f_if_id  = 1'b1;
                f_id_exe = 1'b1;
                if (trap_req || redirect_exe) begin
                    // Restart: this cycle counts as the first of the new flush.
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FLUSH_REST;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (flush_cnt_q <= FCNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCNT_W'(1);
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    // Strobes are forced low during reset so a stall in progress is dropped at once.
    assign stall_if      = reset_n & s_if;
    assign stall_id      = reset_n & s_id;
    assign stall_exe     = reset_n & s_exe;
    assign stall_mem     = reset_n & s_mem;
    assign flush_if_id   = reset_n & f_if_id;
    assign flush_id_exe  = reset_n & f_id_exe;
    assign mem_timeout_o = reset_n & tmo;
    assign stall_count   = stall_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            trap_pend_q   <= 1'b0;
            mdu_done_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            trap_pend_q <= trap_pend_d;
            mdu_done_q  <= mdu_done_d;
            if (s_if && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule
